// File: rtl/rambus_sram_responder_if.sv
// rambus_sram_responder_if
//   Wishbone classic single-word bus between a project's rambus_wb_*
//   initiator and the shared-SRAM responder. Signal names keep the
//   responder-side _i/_o suffixes of the original port list.
//   master : drives cyc/stb/we/sel/adr/dat_i, receives ack/dat_o
//   slave  : receives cyc/stb/we/sel/adr/dat_i, drives ack/dat_o
interface rambus_sram_responder_if;
  logic        rambus_wb_cyc_i;
  logic        rambus_wb_stb_i;
  logic        rambus_wb_we_i;
  logic [3:0]  rambus_wb_sel_i;
  logic [7:0]  rambus_wb_adr_i;
  logic [31:0] rambus_wb_dat_i;
  logic        rambus_wb_ack_o;
  logic [31:0] rambus_wb_dat_o;

  modport master (
    output rambus_wb_cyc_i, rambus_wb_stb_i, rambus_wb_we_i,
    output rambus_wb_sel_i, rambus_wb_adr_i, rambus_wb_dat_i,
    input  rambus_wb_ack_o, rambus_wb_dat_o
  );

  modport slave (
    input  rambus_wb_cyc_i, rambus_wb_stb_i, rambus_wb_we_i,
    input  rambus_wb_sel_i, rambus_wb_adr_i, rambus_wb_dat_i,
    output rambus_wb_ack_o, rambus_wb_dat_o
  );
endinterface

// File: rtl/rambus_sram_responder.sv
// rambus_sram_responder
//   Wishbone classic responder in front of port 0 of a single-port
//   OpenRAM-style SRAM macro. Each bus transaction becomes one RAM access:
//   IDLE -> ACCESS -> (WAIT x RD_LAT for reads) -> ACK -> IDLE.
//
// Parameters
//   RD_LAT    : RAM read latency in cycles after the capture edge (1..3)
//   PROT_BASE : first write-protected word address (RAMBUS_WPROT_EN only)
//
// Ports
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   wb                 : Wishbone slave side (rambus_sram_responder_if)
//   ram_clk0           : RAM clock, a straight copy of wb_clk_i
//   ram_csb0/ram_web0  : active-low chip select / write enable
//   ram_wmask0         : byte write mask
//   ram_addr0/ram_din0 : RAM word address / write data
//   ram_dout0          : RAM read data
//   prot_irq_o         : write-protection violation pulse (RAMBUS_WPROT_EN)
//
// Build option
//   RAMBUS_WPROT_EN : when defined, writes to adr >= PROT_BASE are acked but
//                     suppressed at the RAM, and pulse prot_irq_o with ack.
module rambus_sram_responder #(
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  PROT_BASE = 8'hC0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  rambus_sram_responder_if.slave   wb,
  output logic                     ram_clk0,
  output logic                     ram_csb0,
  output logic                     ram_web0,
  output logic [3:0]               ram_wmask0,
  output logic [7:0]               ram_addr0,
  output logic [31:0]              ram_din0,
  input  logic [31:0]              ram_dout0
`ifdef RAMBUS_WPROT_EN
  ,
  output logic                     prot_irq_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ACK
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic        we_q;
  logic        prot_q;
  logic [31:0] dat_q;
  logic        req;
  logic        prot_hit;
  logic        access_en;

  assign ram_clk0 = wb_clk_i;
  assign req      = wb.rambus_wb_cyc_i & wb.rambus_wb_stb_i;

`ifdef RAMBUS_WPROT_EN
  assign prot_hit = wb.rambus_wb_we_i & (wb.rambus_wb_adr_i >= PROT_BASE);
`else
  logic unused_prot_base;
  assign unused_prot_base = ^PROT_BASE;
  assign prot_hit = 1'b0;
`endif

  // A write with no byte lanes, or to a protected word, still walks the
  // full write sequence but never selects the RAM.
  assign access_en = !(wb.rambus_wb_we_i &&
                       ((wb.rambus_wb_sel_i == 4'h0) || prot_hit));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_nxt = wb.rambus_wb_cyc_i ? ACK : IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd1) begin
          state_nxt = wb.rambus_wb_cyc_i ? ACK : IDLE;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // RAM strobes are registered so they are only low during ACCESS; address,
  // data and mask are loaded only on a new request and otherwise hold.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ram_csb0   <= 1'b1;
      ram_web0   <= 1'b1;
      ram_wmask0 <= '0;
      ram_addr0  <= '0;
      ram_din0   <= '0;
      we_q       <= 1'b0;
      prot_q     <= 1'b0;
      cnt        <= '0;
      dat_q      <= '0;
    end else begin
      ram_csb0 <= 1'b1;
      ram_web0 <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            ram_addr0  <= wb.rambus_wb_adr_i;
            ram_din0   <= wb.rambus_wb_dat_i;
            ram_wmask0 <= wb.rambus_wb_we_i ? wb.rambus_wb_sel_i : 4'h0;
            ram_csb0   <= !access_en;
            ram_web0   <= !wb.rambus_wb_we_i;
            we_q       <= wb.rambus_wb_we_i;
            prot_q     <= prot_hit;
          end
        end
        ACCESS: begin
          cnt <= LAT;
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          // An aborted read leaves the last returned word in place.
          if ((cnt == 2'd1) && wb.rambus_wb_cyc_i) begin
            dat_q <= ram_dout0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wb.rambus_wb_ack_o = (state == ACK);
  assign wb.rambus_wb_dat_o = dat_q;

`ifdef RAMBUS_WPROT_EN
  assign prot_irq_o = (state == ACK) && prot_q;
`endif

endmodule
